// File: rtl/peak_freq_ctrl_pkg.sv
// Shared constants, state type and FFT-size helper for the peak-frequency controller.
package peak_freq_ctrl_pkg;

  localparam int FS_HZ_DEFAULT = 48000;
  localparam int NFFT_MIN      = 7;
  localparam int NFFT_MAX      = 10;
  localparam int NFFT_DEFAULT  = 10;

  typedef enum logic [1:0] {IDLE, SCAN, CONV, HOLD} state_t;

  // Out-of-range FFT sizes fall back to the largest supported size.
  function automatic logic [3:0] nfft_legal(input logic [4:0] sel);
    if (int'(sel) >= NFFT_MIN && int'(sel) <= NFFT_MAX) return sel[3:0];
    return 4'(NFFT_DEFAULT);
  endfunction

endpackage

// File: rtl/peak_freq_ctrl_bin_to_hz.sv
// Two-stage bin-index to Hz converter: stage 1 multiplies by the sample rate,
// stage 2 divides by the FFT size with a truncating shift.
module bin_to_hz
  import peak_freq_ctrl_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int FS_HZ = FS_HZ_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [4:0]       nfft,
  output logic [15:0]      freq_hz
);

  localparam int PROD_W = IDX_W + 16;

  logic [PROD_W-1:0] prod_q;
  logic [4:0]        nfft_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      nfft_q  <= '0;
      freq_hz <= '0;
    end else begin
      prod_q  <= PROD_W'(idx) * PROD_W'(FS_HZ);
      nfft_q  <= nfft;
      freq_hz <= 16'(prod_q >> nfft_legal(nfft_q));
    end
  end

endmodule

// File: rtl/peak_freq_ctrl.sv
// Per-frame arg-max search over the positive-frequency bins of an FFT magnitude
// stream, followed by bin-to-Hz conversion and a valid/ready result hold.
module peak_freq_ctrl
  import peak_freq_ctrl_pkg::*;
#(
  parameter int MAG_W = 32,
  parameter int IDX_W = 10,
  parameter int FS_HZ = FS_HZ_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       nfft_sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [MAG_W-1:0] s_mag,
  input  logic             s_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      freq_hz,
  output logic [IDX_W-1:0] peak_idx,
  output logic [MAG_W-1:0] peak_mag,
  output logic             frame_err,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] bin_cnt;
  logic [IDX_W-1:0] best_idx;
  logic [MAG_W-1:0] best_mag;
  logic [3:0]       nfft_q;
  logic             conv_cnt;
  logic [IDX_W-1:0] last_bin;
  logic [IDX_W-1:0] half_bin;
  logic             beat;
  logic             at_last;
  logic             in_window;
  logic             bad_frame;

  assign s_ready   = (state == IDLE) || (state == SCAN);
  assign beat      = s_valid && s_ready;
  assign last_bin  = IDX_W'((32'd1 << nfft_q) - 32'd1);
  assign half_bin  = IDX_W'(32'd1 << (nfft_q - 4'd1));
  assign at_last   = (state == SCAN) && (bin_cnt == last_bin);
  assign in_window = (state == SCAN) && (bin_cnt != '0) && (bin_cnt < half_bin);
  // s_last must coincide exactly with bin N-1; either mismatch discards the frame.
  assign bad_frame = beat && (s_last != at_last);

  assign peak_idx = best_idx;
  assign peak_mag = best_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (beat) state_nxt = bad_frame ? IDLE : SCAN;
      end
      SCAN: begin
        if (beat) begin
          if (bad_frame)    state_nxt = IDLE;
          else if (at_last) state_nxt = CONV;
        end
      end
      CONV: begin
        if (conv_cnt) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first beat of a frame is bin 0: it latches the FFT size and restarts the search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      best_idx  <= '0;
      best_mag  <= '0;
      nfft_q    <= 4'(NFFT_DEFAULT);
      conv_cnt  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      conv_cnt  <= (state == CONV) ? ~conv_cnt : 1'b0;
      if (beat) begin
        if (state == IDLE) begin
          nfft_q   <= nfft_legal(nfft_sel);
          best_idx <= '0;
          best_mag <= '0;
          bin_cnt  <= IDX_W'(1);
        end else begin
          bin_cnt <= bin_cnt + IDX_W'(1);
          if (in_window && (s_mag > best_mag)) begin
            best_idx <= bin_cnt;
            best_mag <= s_mag;
          end
        end
      end
    end
  end

  bin_to_hz #(
    .IDX_W (IDX_W),
    .FS_HZ (FS_HZ)
  ) u_bin_to_hz (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (best_idx),
    .nfft    ({1'b0, nfft_q}),
    .freq_hz (freq_hz)
  );

endmodule

// File: doc/peak_freq_ctrl.md
# peak_freq_ctrl

Sequences the peak-frequency measurement for one FFT frame. It accepts the magnitude stream from the FFT magnitude stage and tracks the arg-max bin over the positive-frequency half. At frame end it drives the bin index through the bin-to-Hz conversion, then presents the result with a valid/ready handshake. It sits between the FFT magnitude output and the display/UART reporting logic, and owns the per-frame FFT-size latch.

## Interface
- MAG_W, 32: magnitude width (unsigned)
- IDX_W, 10: bin index width (max FFT size 1024)
- FS_HZ, 48000: sample rate used for conversion
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- nfft_sel  in  5  log2 FFT size; legal 7..10, any other value treated as 10; sampled only on the first beat of a frame
- s_valid  in  1  magnitude beat valid
- s_ready  out  1  controller can accept a beat
- s_mag  in  MAG_W  bin magnitude, bins arrive in order 0..N-1
- s_last  in  1  marks final bin of frame (consistency check only)
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- freq_hz  out  16  peak frequency, floor(idx*FS_HZ / 2^nfft)
- peak_idx  out  IDX_W  winning bin
- peak_mag  out  MAG_W  winning magnitude
- frame_err  out  1  one-cycle pulse on framing error
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SCAN, CONV, HOLD.
- IDLE: s_ready=1. An accepted beat (s_valid&s_ready) is bin 0. On that beat, latch nfft (N=2^nfft), clear best to {idx 0, mag 0}, set bin counter to 1, and go to SCAN.
- SCAN: s_ready=1. Each accepted beat increments the counter.
  - Search window is bins 1..N/2-1 inclusive. Bin 0 and bins ≥N/2 are accepted and ignored.
  - Update rule is strict s_mag > best_mag, so ties keep the lowest index. An all-zero frame yields idx 0, freq 0.
- Frame end: the beat with counter==N-1 is accepted.
  - If s_last=1, go to CONV.
  - If s_last=0, pulse frame_err, discard the frame and go to IDLE.
- s_last=1 on any beat with counter≠N-1 (including bin 0): pulse frame_err, discard the frame, go to IDLE. The next beat starts a new frame.
- CONV: s_ready=0. best_idx and latched nfft feed the conversion pipeline for exactly 2 cycles, then the state goes to HOLD.
- HOLD: s_ready=0, out_valid=1. freq_hz, peak_idx and peak_mag are stable until out_ready=1. On the handshake, go to IDLE.
  - out_ready is ignored while out_valid=0.
- Arithmetic:
  - Product idx*FS_HZ is 26 bits unsigned (1023*48000 < 2^26).
  - The shift by nfft truncates toward zero.
  - The result fits 16 bits for all legal idx < N/2.
- nfft_sel changes during SCAN, CONV or HOLD have no effect on the current frame.

## Timing
- Reset (async assert, sync deassert externally):
  - State=IDLE.
  - s_ready=1 in the first cycle after deassert.
  - out_valid=0, freq_hz=0, peak_idx=0, peak_mag=0, frame_err=0, busy=0.
  - Reset mid-frame or mid-HOLD drops everything; no partial result is emitted.
- Throughput: one beat per cycle in IDLE/SCAN.
- Latency: final beat accepted in cycle k, then CONV in cycles k+1 and k+2, then out_valid=1 from cycle k+3.
- Frame rate is bounded by N+3+handshake cycles. Back-pressure is applied only in CONV/HOLD (s_ready=0).
- frame_err asserts in cycle k+1 for an error detected on the beat in cycle k, for one cycle only.
- The final-beat magnitude participates in the compare. For N=128, bin 127 is outside the window, so it never wins.

## Structure
- Shared package constants:
  - FS_HZ default.
  - NFFT_MIN=7, NFFT_MAX=10, NFFT_DEFAULT=10.
  - State enum {IDLE, SCAN, CONV, HOLD}.
- One sub-module, bin_to_hz:
  - Inputs: idx, nfft. Output: freq_hz.
  - 2-stage registered pipeline: stage 1 multiply, stage 2 variable shift with the default-to-10 rule.
  - The controller counts its 2-cycle latency.
- Remaining logic (counter, compare, FSM, output registers) lives in peak_freq_ctrl.

## Test plan
- nfft_sel=10, 1024 beats of zero except bin 100 = 5000, s_last on bin 1023 → peak_idx=100, freq_hz=4687, out_valid in cycle k+3.
- nfft_sel=7, bins 5 and 9 both = 777 (rest 1) → peak_idx=5 (tie, lowest wins), freq_hz=1875. Bin 100 = 9999 must be ignored.
- nfft_sel=3 (illegal) with 1024-beat frame, peak at bin 511 → treated as N=1024, freq_hz=23953.
- nfft_sel=8, s_last asserted on bin 200 → frame_err pulse 1 cycle, no out_valid. The following correct 256-beat frame with peak at bin 64 → freq_hz=12000.
- Hold out_ready=0 for 20 cycles in HOLD while driving s_valid=1 → s_ready=0, outputs stable. Then out_ready=1 → IDLE next cycle, and the next frame is accepted.
- Assert rst_n=0 at bin 300 of a 512 frame → all outputs 0 immediately. After release, a new 512-beat frame with peak at bin 1 → freq_hz=93.
